// File: rtl/niosinst_mul_pkg.sv
// Shared definitions for the multiplier result path.
//   MUL_W       width of a full product word and of each partial product
//   HALF_W      width of one operand half
//   TAG_W_DEF   default width of the destination-register tag
//   pp_bundle_t the three registered partial products {p1, p2, p3}
package niosinst_mul_pkg;

  localparam int MUL_W     = 32;
  localparam int HALF_W    = 16;
  localparam int TAG_W_DEF = 5;

  typedef struct packed {
    logic [MUL_W-1:0] p1;  // src1[15:0]  x src2[15:0]
    logic [MUL_W-1:0] p2;  // src1[15:0]  x src2[31:16]
    logic [MUL_W-1:0] p3;  // src1[31:16] x src2[15:0]
  } pp_bundle_t;

endpackage

// File: rtl/niosinst_mul_result_combine_if.sv
// Valid/ready bundle between the multiplier cell, the result combiner and
// the writeback consumer.
//   in_valid/in_ready              product handshake from the multiplier cell
//   M_mul_cell_p1/p2/p3, in_tag    partial products and destination tag
//   out_valid/out_ready            result handshake towards writeback
//   out_result, out_tag            low 32 bits of the product and its tag
// Modports: slave = the combiner, master = the environment driving it.
interface niosinst_mul_result_combine_if
  import niosinst_mul_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [MUL_W-1:0] M_mul_cell_p1;
  logic [MUL_W-1:0] M_mul_cell_p2;
  logic [MUL_W-1:0] M_mul_cell_p3;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [MUL_W-1:0] out_result;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );

  modport master (
    output in_valid, M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

endinterface

// File: rtl/niosinst_pipe_stage.sv
// Generic valid/ready register slice.
//   clk, reset_n          clock, asynchronous active-low reset
//   flush                 synchronous drop of the held entry
//   in_valid/in_ready     upstream handshake, in_data captured on transfer
//   out_valid/out_ready   downstream handshake, out_data straight from the register
// The slice loads whenever it is empty or its entry leaves this cycle, which
// gives full throughput; in_ready depends combinationally on out_ready.
module niosinst_pipe_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              vld_q;
  logic [DATA_W-1:0] data_q;
  logic              load;

  assign load      = !vld_q || out_ready;
  assign in_ready  = load;
  assign out_valid = vld_q;
  assign out_data  = data_q;

  // An empty-handed load clears the valid, so a drained entry is never replayed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (load) begin
      vld_q <= in_valid;
    end
  end

  // Data is left untouched by flush; only the valid matters after a cancel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (load && in_valid) begin
      data_q <= in_data;
    end
  end

endmodule

// File: rtl/niosinst_mul_result_combine.sv
// Combines the multiplier cell's three 16x16 partial products into the low
// 32-bit word of src1*src2 for writeback.
//   clk, reset_n   clock, asynchronous active-low reset
//   flush          synchronous cancel of every in-flight product
//   busy           high while either stage holds a product
//   bus            slave side of the product/result valid/ready bundle
// Two register slices: stage A folds the two cross products into one 16-bit
// middle term, stage B adds it to the upper half of lo x lo. The cross
// products only reach bits >= 16, so their upper halves never matter and
// both adds wrap; the result is the same for signed and unsigned operands.
module niosinst_mul_result_combine
  import niosinst_mul_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  output logic busy,
  niosinst_mul_result_combine_if.slave bus
);

  localparam int A_W = TAG_W + HALF_W + MUL_W;
  localparam int B_W = TAG_W + MUL_W;

  // Sum truncated to a half word; carries beyond bit 15 fall outside the result.
  function automatic logic [HALF_W-1:0] add_wrap(input logic [MUL_W-1:0] a,
                                                 input logic [MUL_W-1:0] b);
    return HALF_W'(a + b);
  endfunction

  pp_bundle_t        pp_p0;
  logic [HALF_W-1:0] mid_p0;
  logic [A_W-1:0]    data_p0;

  logic              vld_p1;
  logic              rdy_p1;
  logic [A_W-1:0]    data_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic [HALF_W-1:0] mid_p1;
  logic [MUL_W-1:0]  lo_p1;
  logic [HALF_W-1:0] hi_p1;
  logic [B_W-1:0]    res_p1;

  logic              vld_p2;
  logic [B_W-1:0]    data_p2;

  // ---- p0: incoming partial products -> stage A ----
  assign pp_p0   = '{p1: bus.M_mul_cell_p1, p2: bus.M_mul_cell_p2, p3: bus.M_mul_cell_p3};
  assign mid_p0  = add_wrap(pp_p0.p2, pp_p0.p3);
  assign data_p0 = {bus.in_tag, mid_p0, pp_p0.p1};

  niosinst_pipe_stage #(.DATA_W(A_W)) u_stage_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (data_p0),
    .out_valid (vld_p1),
    .out_ready (rdy_p1),
    .out_data  (data_p1)
  );

  // ---- p1: stage A -> stage B ----
  assign tag_p1 = data_p1[A_W-1 -: TAG_W];
  assign mid_p1 = data_p1[MUL_W +: HALF_W];
  assign lo_p1  = data_p1[MUL_W-1:0];
  assign hi_p1  = add_wrap({{(MUL_W-HALF_W){1'b0}}, lo_p1[MUL_W-1:HALF_W]},
                           {{(MUL_W-HALF_W){1'b0}}, mid_p1});
  assign res_p1 = {tag_p1, hi_p1, lo_p1[HALF_W-1:0]};

  niosinst_pipe_stage #(.DATA_W(B_W)) u_stage_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (vld_p1),
    .in_ready  (rdy_p1),
    .in_data   (res_p1),
    .out_valid (vld_p2),
    .out_ready (bus.out_ready),
    .out_data  (data_p2)
  );

  // ---- p2: stage B -> writeback ----
  assign bus.out_valid  = vld_p2;
  assign bus.out_result = data_p2[MUL_W-1:0];
  assign bus.out_tag    = data_p2[B_W-1 -: TAG_W];
  assign busy           = vld_p1 | vld_p2;

endmodule
